// File: rtl/hdmi_pattern_pkg.sv
// hdmi_pattern_pkg: pattern mode encodings, RGB565 colour-bar palette and 565->888 expansion
package hdmi_pattern_pkg;
    typedef enum logic [2:0] {
        MODE_BAR   = 3'd0,
        MODE_RAMP  = 3'd1,
        MODE_GRID  = 3'd2,
        MODE_SOLID = 3'd3,
        MODE_BOX   = 3'd4
    } mode_e;
    localparam logic [15:0] C_WHITE   = 16'hFFFF;
    localparam logic [15:0] C_YELLOW  = 16'hFFE0;
    localparam logic [15:0] C_CYAN    = 16'h07FF;
    localparam logic [15:0] C_GREEN   = 16'h07E0;
    localparam logic [15:0] C_MAGENTA = 16'hF81F;
    localparam logic [15:0] C_RED     = 16'hF800;
    localparam logic [15:0] C_BLUE    = 16'h001F;
    localparam logic [15:0] C_BLACK   = 16'h0000;
    // index 0 is the leftmost bar
    localparam logic [7:0][15:0] BAR_565 = {C_BLACK, C_BLUE, C_RED, C_MAGENTA,
                                            C_GREEN, C_CYAN, C_YELLOW, C_WHITE};
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
        return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
    endfunction
endpackage

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: h/v counters producing raw sync, data enable, active coordinates and frame start
module hdmi_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        frame_start
);
    localparam logic [10:0] H_LAST     = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [10:0] V_LAST     = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
    localparam logic [10:0] H_BEG      = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_END      = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_BEG      = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_END      = 11'(V_SYNC + V_BP + V_ACTIVE);

    logic [10:0] h_cnt, v_cnt;
    logic        h_act, v_act;

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 11'd1;
            if (h_cnt == H_LAST)
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
        end
    end

    always_comb begin
        h_act       = h_cnt >= H_BEG && h_cnt < H_END;
        v_act       = v_cnt >= V_BEG && v_cnt < V_END;
        de          = h_act && v_act;
        hs          = (h_cnt < H_SYNC_END) ? HS_POL : !HS_POL;
        vs          = (v_cnt < V_SYNC_END) ? VS_POL : !VS_POL;
        x           = de ? h_cnt - H_BEG : '0;
        y           = de ? v_cnt - V_BEG : '0;
        frame_start = h_cnt == '0 && v_cnt == '0;
    end
endmodule

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: parametrised video timing plus run-time selectable test patterns,
// registered onto a parallel RGB888 interface with hsync/vsync/de
module hdmi_pattern_gen
    import hdmi_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int GRID     = 64,
    parameter int BOX      = 64
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic [2:0]  mode,
    input  logic [15:0] solid_rgb565,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [23:0] video_rgb,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        frame_start
);
    localparam logic [10:0] BAR_LAST  = 11'(H_ACTIVE / 8 - 1);
    localparam logic [10:0] X_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [10:0] GRID_LAST = 11'(GRID - 1);
    localparam logic [10:0] BOX_W     = 11'(BOX);
    localparam logic [10:0] X_MAX     = 11'(H_ACTIVE - BOX);
    localparam logic [10:0] Y_MAX     = 11'(V_ACTIVE - BOX);

    if (H_ACTIVE < 8 || BOX > H_ACTIVE || BOX > V_ACTIVE || GRID < 1 ||
        H_SYNC + H_BP + H_ACTIVE + H_FP >= 2048 ||
        V_SYNC + V_BP + V_ACTIVE + V_FP >= 2048) begin : g_param_check
        $error("hdmi_pattern_gen: unsupported timing or pattern parameters");
    end

    logic        t_hs, t_vs, t_de, t_fs;
    logic [10:0] t_x, t_y;
    logic [2:0]  mode_q;
    logic [15:0] color_q;
    logic [2:0]  bar_idx;
    logic [10:0] bar_cnt, gx, gy, bx, by, nbx, nby;
    logic        dx, dy, ndx, ndy, started, in_box, bar_next;
    logic [15:0] c565;
    logic [23:0] pat;

    hdmi_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) u_timing (
        .pixel_clk  (pixel_clk),
        .sys_rst    (sys_rst),
        .hs         (t_hs),
        .vs         (t_vs),
        .de         (t_de),
        .x          (t_x),
        .y          (t_y),
        .frame_start(t_fs)
    );

    // a box axis reverses and steps back in the same frame when the next step would leave its range
    always_comb begin
        ndx      = (dx ? bx == X_MAX : bx == '0) ? !dx : dx;
        ndy      = (dy ? by == Y_MAX : by == '0) ? !dy : dy;
        nbx      = (X_MAX == '0) ? bx : ndx ? bx + 11'd1 : bx - 11'd1;
        nby      = (Y_MAX == '0) ? by : ndy ? by + 11'd1 : by - 11'd1;
        in_box   = t_x >= bx && t_x < bx + BOX_W && t_y >= by && t_y < by + BOX_W;
        bar_next = bar_cnt == BAR_LAST && bar_idx != 3'd7;
        c565     = mode_q == MODE_BAR   ? BAR_565[bar_idx] :
                   mode_q == MODE_GRID  ? ((gx == '0 || gy == '0) ? C_WHITE : C_BLACK) :
                   mode_q == MODE_SOLID ? color_q :
                   (mode_q == MODE_BOX && in_box) ? C_RED : C_BLACK;
        pat      = mode_q == MODE_RAMP ? {3{t_x[7:0]}} : rgb565_to_888(c565);
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            mode_q  <= '0;
            color_q <= '0;
            bar_idx <= '0;
            bar_cnt <= '0;
            gx      <= '0;
            gy      <= '0;
            bx      <= '0;
            by      <= '0;
            dx      <= 1'b1;
            dy      <= 1'b1;
            started <= 1'b0;
        end else begin
            if (t_fs) begin
                mode_q  <= mode;
                color_q <= solid_rgb565;
                started <= 1'b1;
                if (started) begin
                    bx <= nbx;
                    by <= nby;
                    dx <= ndx;
                    dy <= ndy;
                end
            end
            // the last bar keeps counting so it absorbs any remainder of the line
            bar_idx <= !t_de ? '0 : bar_next ? bar_idx + 3'd1 : bar_idx;
            bar_cnt <= (!t_de || bar_next) ? '0 : bar_cnt + 11'd1;
            gx      <= (!t_de || gx == GRID_LAST) ? '0 : gx + 11'd1;
            if (t_fs)
                gy <= '0;
            else if (t_de && t_x == X_LAST)
                gy <= (gy == GRID_LAST) ? '0 : gy + 11'd1;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            video_hs    <= !HS_POL;
            video_vs    <= !VS_POL;
            video_de    <= 1'b0;
            video_rgb   <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
        end else begin
            video_hs    <= t_hs;
            video_vs    <= t_vs;
            video_de    <= t_de;
            video_rgb   <= t_de ? pat : '0;
            pixel_x     <= t_x;
            pixel_y     <= t_y;
            frame_start <= t_fs;
        end
    end
endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb_hdmi_pattern_gen: small-timing bench for hdmi_pattern_gen with a frame-arithmetic reference model
module tb_hdmi_pattern_gen;
    localparam int HT = 22;
    localparam int VT = 11;
    localparam int FT = HT * VT;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct {
        logic [2:0]  m;
        logic [15:0] c;
        int          x;
        int          y;
        logic [23:0] rgb;
    } vec_t;

    logic        pixel_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [2:0]  mode = 3'd0;
    logic [2:0]  mode_b = 3'd2;
    logic [15:0] solid = 16'h0000;
    logic        a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs;
    logic [23:0] a_rgb, b_rgb;
    logic [10:0] a_x, a_y, b_x, b_y;
    int          errors = 0, checks = 0, s = -1;
    logic [2:0]  sh_mode = 3'd0;
    logic [15:0] sh_col = 16'h0;
    vec_t        vecs [12];
    int          n, fx, fy, r1, r2, nhs, nvs, nde, nfs, nwb, nlb;
    logic        ph, rose;

    hdmi_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .GRID(4), .BOX(4)
    ) dut_a (
        .pixel_clk(pixel_clk), .sys_rst(sys_rst), .mode(mode), .solid_rgb565(solid),
        .video_hs(a_hs), .video_vs(a_vs), .video_de(a_de), .video_rgb(a_rgb),
        .pixel_x(a_x), .pixel_y(a_y), .frame_start(a_fs)
    );

    hdmi_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .GRID(4), .BOX(4)
    ) dut_b (
        .pixel_clk(pixel_clk), .sys_rst(sys_rst), .mode(mode_b), .solid_rgb565(solid),
        .video_hs(b_hs), .video_vs(b_vs), .video_de(b_de), .video_rgb(b_rgb),
        .pixel_x(b_x), .pixel_y(b_y), .frame_start(b_fs)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic int bounce(int f, int m);
        int p = f % (2 * m);
        return p <= m ? p : 2 * m - p;
    endfunction

    function automatic logic [23:0] exp565(logic [15:0] c);
        int r = int'(c[15:11]);
        int g = int'(c[10:5]);
        int b = int'(c[4:0]);
        return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
    endfunction

    function automatic logic [23:0] pat(logic [2:0] m, logic [15:0] c, int x, int y, int f);
        int bx = bounce(f, 12);
        int by = bounce(f, 4);
        case (m)
            3'd0: return BARS[x / (16 / 8) > 7 ? 7 : x / (16 / 8)];
            3'd1: return {3{8'(x)}};
            3'd2: return (x % 4 == 0 || y % 4 == 0) ? 24'hFFFFFF : 24'h000000;
            3'd3: return exp565(c);
            3'd4: return (x >= bx && x < bx + 4 && y >= by && y < by + 4) ? 24'hFF0000 : 24'h000000;
            default: return 24'h000000;
        endcase
    endfunction

    // outputs seen after the edge that consumed counter state idx (frames counted from reset release)
    function automatic logic [49:0] model(logic r, logic pol, logic [2:0] m, logic [15:0] c, int idx);
        int pos, h, v, x, y;
        logic de;
        if (r) return {~pol, ~pol, 1'b0, 24'h0, 11'd0, 11'd0, 1'b0};
        pos = idx % FT;
        h = pos % HT;
        v = pos / HT;
        de = h >= 4 && h < 20 && v >= 2 && v < 10;
        x = de ? h - 4 : 0;
        y = de ? v - 2 : 0;
        return {h < 2 ? pol : ~pol, v < 1 ? pol : ~pol, de,
                de ? pat(m, c, x, y, idx / FT) : 24'h0, 11'(x), 11'(y), pos == 0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at s=%0d: got %h, expected %h", name, s, act, exp);
        end
    endtask

    task automatic step();
        logic r;
        @(posedge pixel_clk);
        r = sys_rst;
        if (r) s = -1;
        else begin
            s++;
            if (s % FT == 0) begin
                sh_mode = mode;
                sh_col = solid;
            end
        end
        @(negedge pixel_clk);
        check("dut_a_outputs", {a_hs, a_vs, a_de, a_rgb, a_x, a_y, a_fs}, model(r, 1'b1, sh_mode, sh_col, s));
        check("dut_b_outputs", {b_hs, b_vs, b_de, b_rgb, b_x, b_y, b_fs}, model(r, 1'b0, 3'd2, 16'h0, s));
    endtask

    task automatic wait_fs();
        int k = 0;
        do begin step(); k++; end while (!a_fs && k < 2 * FT);
        check("wait_frame_start", 64'(a_fs), 64'd1);
    endtask

    task automatic wait_px(input int x, input int y);
        int k = 0;
        do begin step(); k++; end while (!(a_de && a_x == 11'(x) && a_y == 11'(y)) && k < FT);
        check("wait_pixel", 64'(a_de && a_x == 11'(x) && a_y == 11'(y)), 64'd1);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 16'h0000, 0, 0, 24'hFFFFFF};
        vecs[1]  = '{3'd0, 16'h0000, 14, 3, 24'h000000};
        vecs[2]  = '{3'd0, 16'h0000, 2, 5, 24'hFFFF00};
        vecs[3]  = '{3'd0, 16'h0000, 10, 7, 24'hFF0000};
        vecs[4]  = '{3'd0, 16'h0000, 15, 0, 24'h000000};
        vecs[5]  = '{3'd1, 16'h0000, 9, 2, 24'h090909};
        vecs[6]  = '{3'd2, 16'h0000, 4, 1, 24'hFFFFFF};
        vecs[7]  = '{3'd2, 16'h0000, 5, 1, 24'h000000};
        vecs[8]  = '{3'd2, 16'h0000, 5, 4, 24'hFFFFFF};
        vecs[9]  = '{3'd3, 16'hF800, 5, 5, 24'hFF0000};
        vecs[10] = '{3'd3, 16'h001F, 0, 0, 24'h0000FF};
        vecs[11] = '{3'd3, 16'h07E0, 15, 7, 24'h00FF00};

        repeat (3) step();
        check("reset_a_ctrl", {a_hs, a_vs, a_de, a_fs, a_rgb}, 64'd0);
        check("reset_b_sync", {b_hs, b_vs}, 64'd3);
        sys_rst = 1'b0;

        nhs = 0; nvs = 0; nde = 0; nfs = 0; nwb = 0; nlb = 0; r1 = -1; r2 = -1; ph = a_hs;
        repeat (FT) begin
            step();
            nhs += int'(a_hs);
            nvs += int'(a_vs);
            nde += int'(a_de);
            nfs += int'(a_fs);
            nwb += int'(b_de && b_rgb == 24'hFFFFFF);
            nlb += int'(!b_hs);
            if (a_hs && !ph) begin
                if (r1 < 0) r1 = s;
                else if (r2 < 0) r2 = s;
            end
            ph = a_hs;
        end
        check("hs_active_cycles", 64'(nhs), 64'd22);
        check("vs_active_cycles", 64'(nvs), 64'd22);
        check("de_cycles", 64'(nde), 64'd128);
        check("frame_start_pulses", 64'(nfs), 64'd1);
        check("hs_period", 64'(r2 - r1), 64'd22);
        check("grid_white_pixels", 64'(nwb), 64'd56);
        check("b_hs_low_cycles", 64'(nlb), 64'd22);

        for (int i = 0; i < 12; i++) begin
            mode = vecs[i].m;
            solid = vecs[i].c;
            wait_fs();
            wait_px(vecs[i].x, vecs[i].y);
            check($sformatf("vec%0d_rgb", i), 64'(a_rgb), 64'(vecs[i].rgb));
        end

        mode = 3'd0;
        wait_fs();
        wait_px(0, 2);
        mode = 3'd3;
        solid = 16'hF800;
        wait_px(0, 3);
        check("mid_frame_keeps_bars", 64'(a_rgb), 64'hFFFFFF);
        wait_fs();
        n = 0;
        do begin step(); n++; end while (!a_de && n < FT);
        check("next_frame_solid", 64'(a_rgb), 64'hFF0000);

        mode = 3'd0;
        wait_px(5, 4);
        sys_rst = 1'b1;
        repeat (3) begin
            step();
            check("rst_hold", {a_hs, a_vs, a_de, a_fs, a_rgb, a_x, a_y}, 64'd0);
        end
        sys_rst = 1'b0;
        step();
        check("fs_after_release", 64'(a_fs), 64'd1);
        n = 0; ph = a_hs; rose = 1'b0;
        do begin step(); n++; rose = a_hs && !ph; ph = a_hs; end while (!rose && n < 40);
        check("hs_after_release", 64'(n), 64'd22);

        mode = 3'd4;
        sys_rst = 1'b1;
        repeat (2) step();
        sys_rst = 1'b0;
        for (int f = 0; f < 14; f++) begin
            fx = -1; fy = -1;
            repeat (FT) begin
                step();
                if (fx < 0 && a_de && a_rgb == 24'hFF0000) begin
                    fx = int'(a_x);
                    fy = int'(a_y);
                end
            end
            check($sformatf("box_x_f%0d", f), 64'(fx), 64'(bounce(f, 12)));
            check($sformatf("box_y_f%0d", f), 64'(fy), 64'(bounce(f, 4)));
            if (f == 13) check("box_x_after_reverse", 64'(fx), 64'd11);
        end

        repeat (5000) begin
            if ($urandom_range(0, 99) < 2) mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 2) solid = 16'($urandom);
            sys_rst = $urandom_range(0, 999) < 3;
            step();
        end
        sys_rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
